// File: rtl/ahb_apb_bridge_mp_if.sv
// AHB-lite / APB signal bundle for the parametrised bridge.
// slave: the bridge's view (AHB slave, APB master side driven by the bridge).
// master: the surrounding system's view (AHB master plus APB peripherals).
interface ahb_apb_bridge_mp_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 3
);
  // AHB side
  logic [1:0]         Htrans;
  logic               Hwrite;
  logic               Hreadyin;
  logic [ADDR_W-1:0]  Haddr;
  logic [DATA_W-1:0]  Hwdata;
  logic               Hreadyout;
  logic [1:0]         Hresp;
  logic [DATA_W-1:0]  Hrdata;
  // APB side
  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [ADDR_W-1:0]  Paddr;
  logic [DATA_W-1:0]  Pwdata;
  logic [DATA_W-1:0]  Prdata;
  logic               Pready;
  logic               Pslverr;

  modport slave (
    input  Htrans, Hwrite, Hreadyin, Haddr, Hwdata, Prdata, Pready, Pslverr,
    output Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport master (
    output Htrans, Hwrite, Hreadyin, Haddr, Hwdata, Prdata, Pready, Pslverr,
    input  Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/ahb_apb_bridge_mp.sv
// Parametrised AHB-lite to APB bridge with one-hot slave decode, APB wait
// states, slave-error forwarding, decode-miss ERROR and an APB wait timeout.
// Every output is decoded from registered state only.
module ahb_apb_bridge_mp #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int unsigned       SLOT_BITS = 24,
  parameter int unsigned       WAIT_MAX  = 16
) (
  input logic                Hclk,
  input logic                Hresetn,
  ahb_apb_bridge_mp_if.slave bus
);

  localparam int unsigned IDX_W   = (NUM_SLV <= 2) ? 1 : $clog2(NUM_SLV);
  localparam int unsigned REG_LSB = SLOT_BITS + IDX_W;
  localparam int unsigned CNT_W   = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);
  // Count value seen in the WAIT_MAX-th ACCESS cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  idx;
  logic              region_hit;
  logic              idx_ok;
  logic              accept;

  assign idx        = bus.Haddr[SLOT_BITS +: IDX_W];
  // When the slot index reaches the top address bit there are no region bits
  // left; both shifts then give zero and everything lands in the region.
  assign region_hit = (bus.Haddr >> REG_LSB) == (BASE_ADDR >> REG_LSB);
  assign idx_ok     = 32'(idx) < NUM_SLV;
  assign accept     = ((state_q == StIdle) || (state_q == StErr2)) &&
                      bus.Hreadyin && bus.Htrans[1];

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          paddr_d  = bus.Haddr;
          pwrite_d = bus.Hwrite;
          sel_d    = idx;
          if (!(region_hit && idx_ok)) begin
            state_d = StErr1;
          end else if (bus.Hwrite) begin
            state_d = StWdata;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StWdata: begin
        pwdata_d = bus.Hwdata;
        state_d  = StSetup;
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (bus.Pready) begin
          if (bus.Pslverr) begin
            state_d = StErr1;
          end else begin
            state_d = StIdle;
            if (!pwrite_q) begin
              hrdata_d = bus.Prdata;
            end
          end
        end else if ((WAIT_MAX != 0) && (cnt_q == CNT_LAST)) begin
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    bus.Pselx = '0;
    if ((state_q == StSetup) || (state_q == StAccess)) begin
      for (int i = 0; i < int'(NUM_SLV); i++) begin
        bus.Pselx[i] = (sel_q == IDX_W'(i));
      end
    end
    bus.Penable   = (state_q == StAccess);
    bus.Hreadyout = (state_q == StIdle) || (state_q == StErr2);
    bus.Hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
    bus.Pwrite    = pwrite_q;
    bus.Paddr     = paddr_q;
    bus.Pwdata    = pwdata_q;
    bus.Hrdata    = hrdata_q;
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Self-checking bench for ahb_apb_bridge_mp: directed scenarios plus a
// randomized run, each transfer checked against a transaction-level model.
module tb_ahb_apb_bridge_mp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          NSLV  = 3;
  localparam int          WMAX  = 4;
  localparam int          STUCK = 1000;

  typedef struct packed {
    logic [7:0]  busy;        // cycles with Hreadyout=0 after the address phase
    logic [7:0]  acc;         // cycles with Penable=1
    logic [2:0]  sel;         // OR of Pselx over the transfer
    logic        order_ok;    // SETUP then ACCESS pairing, Pselx off at the end
    logic [7:0]  first_err;   // busy cycle index where Hresp first non-zero
    logic [1:0]  final_resp;  // Hresp when Hreadyout returns to 1
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } obs_t;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] m_pwdata = '0;
  logic [31:0] m_hrdata = '0;

  ahb_apb_bridge_mp_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NSLV)) bus ();

  ahb_apb_bridge_mp #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .NUM_SLV  (NSLV),
    .BASE_ADDR(BASE),
    .SLOT_BITS(24),
    .WAIT_MAX (WMAX)
  ) dut (
    .Hclk   (Hclk),
    .Hresetn(Hresetn),
    .bus    (bus.slave)
  );

  always #5 Hclk = ~Hclk;
  always @(posedge Hclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  // Transaction-level expectation: decode by address arithmetic, latency by
  // counting phases, and the architectural Pwdata/Hrdata registers.
  task automatic model(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input int nwait, input logic serr, input logic [31:0] rd,
                       output obs_t e);
    longint off;
    int     slot;
    int     acc;
    bit     hit, tmo, err;
    e = '0;
    e.order_ok = 1'b1;
    off  = longint'(addr) - longint'(BASE);
    slot = int'(off / (64'd1 << 24));
    hit  = (off >= 0) && (slot < NSLV);
    if (!hit) begin
      e.busy       = 8'd1;
      e.first_err  = 8'd1;
      e.final_resp = 2'b01;
      return;
    end
    tmo = (nwait >= WMAX);
    err = tmo || serr;
    acc = tmo ? WMAX : nwait + 1;
    if (wr) m_pwdata = wd;
    if (!wr && !err) m_hrdata = rd;
    e.sel        = 3'(1 << slot);
    e.acc        = 8'(acc);
    e.busy       = 8'(int'(wr) + 1 + acc + int'(err));
    e.first_err  = err ? e.busy : 8'd0;
    e.final_resp = err ? 2'b01 : 2'b00;
    e.pwrite     = wr;
    e.paddr      = addr;
    e.pwdata     = m_pwdata;
  endtask

  // Drive one AHB transfer, act as the APB slave, and record what happened.
  // Starts and ends in a cycle with Hreadyout=1.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int nwait, input logic serr, input logic [31:0] rd,
                         output obs_t o);
    int         acc;
    logic [2:0] prev_sel;
    o = '0;
    o.order_ok = 1'b1;
    acc = 0;
    prev_sel = '0;
    bus.Htrans   = 2'b10;
    bus.Haddr    = addr;
    bus.Hwrite   = wr;
    bus.Hreadyin = 1'b1;
    tick();
    bus.Hwdata = wd;
    while (bus.Hreadyout !== 1'b1) begin
      o.busy++;
      // A pending next address must be ignored while the bridge is busy.
      bus.Htrans = {1'b1, 1'($urandom)};
      bus.Haddr  = BASE + ($urandom & 32'h0300_00ff);
      bus.Hwrite = 1'($urandom);
      if (bus.Hresp !== 2'b00 && o.first_err == 0) o.first_err = o.busy;
      if (bus.Penable === 1'b1 && (bus.Pselx == 0 || prev_sel == 0)) o.order_ok = 1'b0;
      if (bus.Penable !== 1'b1 && bus.Pselx != 0 && prev_sel != 0) o.order_ok = 1'b0;
      o.sel |= bus.Pselx;
      if (bus.Penable === 1'b1) begin
        acc++;
        o.acc++;
        o.paddr  = bus.Paddr;
        o.pwdata = bus.Pwdata;
        o.pwrite = bus.Pwrite;
        bus.Pready  = (acc > nwait);
        bus.Pslverr = bus.Pready ? serr : 1'($urandom);
        bus.Prdata  = bus.Pready ? rd : $urandom;
      end else begin
        bus.Pready  = 1'($urandom);
        bus.Pslverr = 1'($urandom);
        bus.Prdata  = $urandom;
      end
      prev_sel = bus.Pselx;
      if (o.busy >= 60) begin
        checks++;
        $display("FAIL xfer_bound: Hreadyout still 0 after %0d cycles, required back by 60",
                 o.busy);
        break;
      end
      tick();
    end
    if (bus.Pselx != 0) o.order_ok = 1'b0;
    o.final_resp = bus.Hresp;
    bus.Htrans = 2'b00;
    bus.Hwdata = $urandom;
  endtask

  task automatic test_reset();
    bus.Htrans = 2'b00; bus.Hwrite = 1'b0; bus.Hreadyin = 1'b1;
    bus.Haddr = '0; bus.Hwdata = '0; bus.Prdata = '0; bus.Pready = 1'b0; bus.Pslverr = 1'b0;
    Hresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Hresp} !== 8'b000_0_0_1_00)
      $display("FAIL reset_ctrl: sel=%b en=%b wr=%b rdy=%b resp=%b, required 000 0 0 1 00",
               bus.Pselx, bus.Penable, bus.Pwrite, bus.Hreadyout, bus.Hresp);
    else passed++;
    checks++;
    if (bus.Paddr !== 32'h0) $display("FAIL reset_paddr: got %h required 0", bus.Paddr);
    else passed++;
    checks++;
    if (bus.Pwdata !== 32'h0) $display("FAIL reset_pwdata: got %h required 0", bus.Pwdata);
    else passed++;
    checks++;
    if (bus.Hrdata !== 32'h0) $display("FAIL reset_hrdata: got %h required 0", bus.Hrdata);
    else passed++;
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick();
  endtask

  task automatic test_pipelined_writes();
    logic [31:0] a[4] = '{32'h8000_0004, 32'h8000_0055, 32'h8000_0066, 32'h8000_0077};
    logic [31:0] d[4] = '{32'hA5A5_5A5A, 32'hEAEA_EAEA, 32'hBABA_BABA, 32'hDEAD_BEEF};
    obs_t o, e;
    int   t0;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      model(a[i], 1'b1, d[i], 0, 1'b0, 32'h0, e);
      do_xfer(a[i], 1'b1, d[i], 0, 1'b0, 32'h0, o);
      checks++;
      if (o !== e) $display("FAIL write%0d: got %p required %p", i, o, e);
      else passed++;
    end
    checks++;
    if (cyc - t0 !== 16) $display("FAIL write_cycles: got %0d required 16", cyc - t0);
    else passed++;
  endtask

  task automatic test_wait_read();
    obs_t o, e;
    model(32'h8100_0010, 1'b0, 32'h0, 2, 1'b0, 32'h1234_5678, e);
    do_xfer(32'h8100_0010, 1'b0, 32'h0, 2, 1'b0, 32'h1234_5678, o);
    checks++;
    if (o !== e) $display("FAIL wait_read: got %p required %p", o, e);
    else passed++;
    checks++;
    if (bus.Hrdata !== 32'h1234_5678)
      $display("FAIL wait_read_hrdata: got %h required 12345678", bus.Hrdata);
    else passed++;
  endtask

  task automatic test_decode_miss();
    logic [31:0] a[2] = '{32'h8300_0000, 32'h9000_0000};
    obs_t o, e;
    for (int i = 0; i < 2; i++) begin
      model(a[i], 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_0000, e);
      do_xfer(a[i], 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_0000, o);
      checks++;
      if (o !== e) $display("FAIL miss%0d: got %p required %p", i, o, e);
      else passed++;
      checks++;
      if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b01)
        $display("FAIL miss%0d_err2: rdy=%b resp=%b required 1 01", i, bus.Hreadyout, bus.Hresp);
      else passed++;
    end
    checks++;
    if (bus.Hrdata !== m_hrdata)
      $display("FAIL miss_hrdata: got %h required %h", bus.Hrdata, m_hrdata);
    else passed++;
  endtask

  task automatic test_slverr();
    obs_t o, e;
    model(32'h8200_0000, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 32'h0, e);
    do_xfer(32'h8200_0000, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 32'h0, o);
    checks++;
    if (o !== e) $display("FAIL slverr: got %p required %p", o, e);
    else passed++;
    checks++;
    if (bus.Hrdata !== m_hrdata)
      $display("FAIL slverr_hrdata: got %h required %h", bus.Hrdata, m_hrdata);
    else passed++;
  endtask

  task automatic test_timeout();
    int          nw[3] = '{STUCK, 0, WMAX - 1};
    logic [31:0] rd;
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      rd = $urandom;
      model(32'h8000_0020, 1'b0, 32'h0, nw[i], 1'b0, rd, e);
      do_xfer(32'h8000_0020, 1'b0, 32'h0, nw[i], 1'b0, rd, o);
      checks++;
      if (o !== e) $display("FAIL timeout%0d: got %p required %p", i, o, e);
      else passed++;
      checks++;
      if (bus.Hrdata !== m_hrdata)
        $display("FAIL timeout%0d_hrdata: got %h required %h", i, bus.Hrdata, m_hrdata);
      else passed++;
    end
  endtask

  task automatic test_ignore();
    bus.Haddr = 32'h8000_0040; bus.Hwrite = 1'b0; bus.Hreadyin = 1'b1;
    bus.Htrans = 2'b01;
    tick();
    checks++;
    if (bus.Hreadyout !== 1'b1 || bus.Pselx !== 3'b000 || bus.Hresp !== 2'b00)
      $display("FAIL ignore_busy: rdy=%b sel=%b resp=%b required 1 000 00",
               bus.Hreadyout, bus.Pselx, bus.Hresp);
    else passed++;
    bus.Htrans = 2'b10; bus.Hreadyin = 1'b0;
    tick();
    checks++;
    if (bus.Hreadyout !== 1'b1 || bus.Pselx !== 3'b000 || bus.Hresp !== 2'b00)
      $display("FAIL ignore_hreadyin: rdy=%b sel=%b resp=%b required 1 000 00",
               bus.Hreadyout, bus.Pselx, bus.Hresp);
    else passed++;
    bus.Htrans = 2'b00; bus.Hreadyin = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[3] = '{32'h8300_0100, 32'h8100_0200, 32'h8200_0300};
    logic        w[3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] rd, wd;
    obs_t o, e;
    int   t0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      rd = $urandom;
      wd = $urandom;
      model(a[i], w[i], wd, 0, 1'b0, rd, e);
      do_xfer(a[i], w[i], wd, 0, 1'b0, rd, o);
      checks++;
      if (o !== e) $display("FAIL b2b%0d: got %p required %p", i, o, e);
      else passed++;
    end
    checks++;
    if (cyc - t0 !== 9) $display("FAIL b2b_cycles: got %0d required 9", cyc - t0);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd;
    logic        wr, serr;
    int          slot, nwait;
    obs_t o, e;
    for (int i = 0; i < 40; i++) begin
      slot  = $urandom_range(0, 4);
      addr  = (slot < 4) ? BASE + (32'(slot) << 24) + ($urandom & 32'h00ff_ffff) : $urandom;
      wr    = 1'($urandom);
      wd    = $urandom;
      rd    = $urandom;
      nwait = $urandom_range(0, WMAX + 1);
      serr  = ($urandom_range(0, 5) == 0);
      model(addr, wr, wd, nwait, serr, rd, e);
      do_xfer(addr, wr, wd, nwait, serr, rd, o);
      checks++;
      if (o !== e) $display("FAIL rand%0d a=%h w=%b n=%0d s=%b: got %p required %p",
                            i, addr, wr, nwait, serr, o, e);
      else passed++;
      checks++;
      if (bus.Hrdata !== m_hrdata)
        $display("FAIL rand%0d_hrdata: got %h required %h", i, bus.Hrdata, m_hrdata);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bus.Htrans = 2'b10; bus.Haddr = 32'h8000_0100; bus.Hwrite = 1'b0; bus.Hreadyin = 1'b1;
    bus.Pready = 1'b0;
    tick();
    bus.Htrans = 2'b00;
    tick();
    checks++;
    if (bus.Penable !== 1'b1 || bus.Pselx !== 3'b001)
      $display("FAIL mid_access: en=%b sel=%b required 1 001", bus.Penable, bus.Pselx);
    else passed++;
    #2;
    Hresetn = 1'b0;
    #1;
    checks++;
    if (bus.Pselx !== 3'b000 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b1 ||
        bus.Hresp !== 2'b00)
      $display("FAIL mid_reset: sel=%b en=%b rdy=%b resp=%b required 000 0 1 00",
               bus.Pselx, bus.Penable, bus.Hreadyout, bus.Hresp);
    else passed++;
    checks++;
    if (bus.Hrdata !== 32'h0 || bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0)
      $display("FAIL mid_reset_regs: hrdata=%h paddr=%h pwdata=%h required 0 0 0",
               bus.Hrdata, bus.Paddr, bus.Pwdata);
    else passed++;
    m_hrdata = '0;
    m_pwdata = '0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick();
  endtask

  task automatic test_after_reset();
    obs_t o, e;
    model(32'h8100_0abc, 1'b0, 32'h0, 1, 1'b0, 32'hC0FF_EE11, e);
    do_xfer(32'h8100_0abc, 1'b0, 32'h0, 1, 1'b0, 32'hC0FF_EE11, o);
    checks++;
    if (o !== e) $display("FAIL after_reset: got %p required %p", o, e);
    else passed++;
    checks++;
    if (bus.Hrdata !== 32'hC0FF_EE11)
      $display("FAIL after_reset_hrdata: got %h required c0ffee11", bus.Hrdata);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pipelined_writes();
    test_wait_read();
    test_decode_miss();
    test_slverr();
    test_timeout();
    test_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_after_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
